// File: rtl/usb_hub_pkg.sv
// Shared USB definitions: transmitter state encoding, line levels and framing constants.
package usb_hub_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_t;

  typedef enum logic [1:0] {
    SYM_BIT,
    SYM_SE0,
    SYM_J
  } sym_kind_t;

  typedef struct packed {
    logic plus;
    logic minus;
  } line_t;

  localparam logic [7:0]  SYNC_PATTERN = 8'h80;
  localparam int unsigned STUFF_LIMIT  = 6;
  localparam int unsigned ONES_W       = 3;

  // Full-speed J/K; low speed swaps them, SE0 is the same for both.
  localparam line_t LINE_J_FS = line_t'(2'b10);
  localparam line_t LINE_K_FS = line_t'(2'b01);
  localparam line_t LINE_SE0  = line_t'(2'b00);

  function automatic line_t line_level(input logic is_j, input logic low_speed);
    return (is_j ^ low_speed) ? LINE_J_FS : LINE_K_FS;
  endfunction

endpackage

// File: rtl/usb_nrzi_stuffer.sv
// NRZI encoder with consecutive-ones counter; owns the registered D+/D- levels.
module usb_nrzi_stuffer
  import usb_hub_pkg::*;
#(
  parameter int unsigned LOW_SPEED = 0
) (
  input  logic      hi_clock,
  input  logic      reset,
  input  logic      i_init,
  input  logic      i_adv,
  input  sym_kind_t i_sym,
  input  logic      i_bit,
  output logic      o_stuff,
  output line_t     o_line
);

  localparam logic LS = (LOW_SPEED != 0);

  logic              r_level;
  logic [ONES_W-1:0] r_ones;
  line_t             r_line;

  logic              w_level_base;
  logic [ONES_W-1:0] w_ones_base;
  logic              w_level_nxt;
  logic [ONES_W-1:0] w_ones_nxt;
  line_t             w_line_nxt;

  // r_level is 1 for J; i_init restarts the packet at J before the new symbol is applied.
  always_comb begin
    w_level_base = i_init ? 1'b1 : r_level;
    w_ones_base  = i_init ? '0 : r_ones;
    w_level_nxt  = w_level_base;
    w_ones_nxt   = w_ones_base;
    w_line_nxt   = r_line;
    if (i_adv) begin
      case (i_sym)
        SYM_BIT: begin
          if (i_bit) begin
            w_ones_nxt = w_ones_base + ONES_W'(1);
          end else begin
            w_level_nxt = ~w_level_base;
            w_ones_nxt  = '0;
          end
          w_line_nxt = line_level(w_level_nxt, LS);
        end
        SYM_SE0: w_line_nxt = LINE_SE0;
        default: w_line_nxt = line_level(1'b1, LS);
      endcase
    end
  end

  always_ff @(posedge hi_clock) begin
    if (reset) begin
      r_level <= 1'b1;
      r_ones  <= '0;
      r_line  <= line_level(1'b1, LS);
    end else begin
      r_level <= w_level_nxt;
      r_ones  <= w_ones_nxt;
      r_line  <= w_line_nxt;
    end
  end

  assign o_stuff = (r_ones == ONES_W'(STUFF_LIMIT));
  assign o_line  = r_line;

endmodule

// File: rtl/usb_tx_serializer.sv
// USB packet transmitter: SYNC, LSB-first byte stream with bit stuffing, EOP.
// CLKS_PER_BIT must be at least 2 (the byte fetch cycle is announced one clock ahead).
module usb_tx_serializer
  import usb_hub_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned LOW_SPEED    = 0
) (
  input  logic       hi_clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_plus,
  output logic       tx_minus,
  output logic       tx_oe,
  output logic       tx_busy,
  output logic       tx_underrun
);

  localparam int unsigned    CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  tx_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_bit_cnt, w_cnt_nxt;
  logic [2:0]       r_bit_idx, w_idx_nxt;
  logic             r_stuffing, w_stuffing_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_last, w_last_nxt;
  logic             r_have_next, w_have_next_nxt;
  logic             r_tx_ready, w_ready_nxt;
  logic             r_tx_oe, r_tx_busy;
  logic             r_tx_underrun, w_underrun_nxt;

  logic      w_sym_end;
  logic      w_adv;
  logic      w_init;
  sym_kind_t w_sym;
  logic      w_bit;
  logic      w_stuff_req;
  line_t     w_line;

  assign w_sym_end = (r_bit_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = w_sym_end ? '0 : r_bit_cnt + CNT_W'(1);
    w_idx_nxt       = r_bit_idx;
    w_stuffing_nxt  = r_stuffing;
    w_shift_nxt     = r_shift;
    w_last_nxt      = r_last;
    w_have_next_nxt = r_have_next;
    w_ready_nxt     = 1'b0;
    w_underrun_nxt  = 1'b0;
    w_adv           = 1'b0;
    w_init          = 1'b0;
    w_sym           = SYM_BIT;
    w_bit           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (tx_valid && r_tx_ready) begin
          w_state_nxt     = ST_SYNC;
          w_shift_nxt     = tx_data;
          w_last_nxt      = tx_last;
          w_have_next_nxt = 1'b0;
          w_idx_nxt       = '0;
          w_stuffing_nxt  = 1'b0;
          w_adv           = 1'b1;
          w_init          = 1'b1;
          w_bit           = SYNC_PATTERN[0];
        end
      end
      ST_SYNC: begin
        if (w_sym_end) begin
          w_adv = 1'b1;
          if (r_bit_idx != 3'd7) begin
            w_idx_nxt = r_bit_idx + 3'd1;
            w_bit     = SYNC_PATTERN[w_idx_nxt];
          end else begin
            w_state_nxt = ST_DATA;
            w_idx_nxt   = '0;
            w_bit       = r_shift[0];
          end
        end
      end
      ST_DATA: begin
        // Fetch window: r_tx_ready is only high in the last clock of bit 7 here.
        if (r_tx_ready) begin
          if (tx_valid) begin
            w_shift_nxt     = tx_data;
            w_last_nxt      = tx_last;
            w_have_next_nxt = 1'b1;
          end else begin
            w_underrun_nxt = 1'b1;
          end
        end
        if (!r_stuffing && (r_bit_idx == 3'd7) && !r_last && (r_bit_cnt == CNT_PRE)) begin
          w_ready_nxt = 1'b1;
        end
        if (w_sym_end) begin
          w_adv          = 1'b1;
          w_stuffing_nxt = 1'b0;
          if (w_stuff_req) begin
            w_stuffing_nxt = 1'b1;
            w_bit          = 1'b0;
          end else if (r_bit_idx != 3'd7) begin
            w_idx_nxt = r_bit_idx + 3'd1;
            w_bit     = r_shift[w_idx_nxt];
          end else if (w_have_next_nxt) begin
            w_idx_nxt       = '0;
            w_bit           = w_shift_nxt[0];
            w_have_next_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_EOP_SE0;
            w_idx_nxt   = '0;
            w_sym       = SYM_SE0;
          end
        end
      end
      ST_EOP_SE0: begin
        if (w_sym_end) begin
          if (r_bit_idx == 3'd0) begin
            w_idx_nxt = 3'd1;
          end else begin
            w_state_nxt = ST_EOP_J;
            w_idx_nxt   = '0;
            w_adv       = 1'b1;
            w_sym       = SYM_J;
          end
        end
      end
      ST_EOP_J: begin
        if (w_sym_end) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_state_nxt == ST_IDLE) begin
      w_ready_nxt = 1'b1;
    end
  end

  always_ff @(posedge hi_clock) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= '0;
      r_bit_idx     <= '0;
      r_stuffing    <= 1'b0;
      r_shift       <= '0;
      r_last        <= 1'b0;
      r_have_next   <= 1'b0;
      r_tx_ready    <= 1'b0;
      r_tx_oe       <= 1'b0;
      r_tx_busy     <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_bit_cnt     <= w_cnt_nxt;
      r_bit_idx     <= w_idx_nxt;
      r_stuffing    <= w_stuffing_nxt;
      r_shift       <= w_shift_nxt;
      r_last        <= w_last_nxt;
      r_have_next   <= w_have_next_nxt;
      r_tx_ready    <= w_ready_nxt;
      r_tx_oe       <= (w_state_nxt != ST_IDLE);
      r_tx_busy     <= (w_state_nxt != ST_IDLE);
      r_tx_underrun <= w_underrun_nxt;
    end
  end

  usb_nrzi_stuffer #(
    .LOW_SPEED(LOW_SPEED)
  ) u_nrzi (
    .hi_clock(hi_clock),
    .reset   (reset),
    .i_init  (w_init),
    .i_adv   (w_adv),
    .i_sym   (w_sym),
    .i_bit   (w_bit),
    .o_stuff (w_stuff_req),
    .o_line  (w_line)
  );

  assign tx_ready    = r_tx_ready;
  assign tx_plus     = w_line.plus;
  assign tx_minus    = w_line.minus;
  assign tx_oe       = r_tx_oe;
  assign tx_busy     = r_tx_busy;
  assign tx_underrun = r_tx_underrun;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Directed bench for usb_tx_serializer: full- and low-speed instances share stimulus.
module tb_usb_tx_serializer;

  logic       hi_clock = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last  = 1'b0;

  logic fs_ready, fs_plus, fs_minus, fs_oe, fs_busy, fs_underrun;
  logic ls_ready, ls_plus, ls_minus, ls_oe, ls_busy, ls_underrun;

  int errors = 0;
  int checks = 0;

  always #5 hi_clock = ~hi_clock;

  usb_tx_serializer #(.CLKS_PER_BIT(4), .LOW_SPEED(0)) u_fs (
    .hi_clock(hi_clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_last(tx_last), .tx_ready(fs_ready), .tx_plus(fs_plus), .tx_minus(fs_minus),
    .tx_oe(fs_oe), .tx_busy(fs_busy), .tx_underrun(fs_underrun)
  );

  usb_tx_serializer #(.CLKS_PER_BIT(4), .LOW_SPEED(1)) u_ls (
    .hi_clock(hi_clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_last(tx_last), .tx_ready(ls_ready), .tx_plus(ls_plus), .tx_minus(ls_minus),
    .tx_oe(ls_oe), .tx_busy(ls_busy), .tx_underrun(ls_underrun)
  );

  // Symbol letter to {D+, D-}: 'J', 'K', '0' = SE0.
  function automatic logic [1:0] exp_line(input byte c, input bit ls);
    if (c == "J") return ls ? 2'b01 : 2'b10;
    if (c == "K") return ls ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge hi_clock);
    checks++;
    if (fs_ready !== 1'b0 || fs_oe !== 1'b0 || fs_busy !== 1'b0 || fs_underrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: ready=%b oe=%b busy=%b underrun=%b, required all 0",
               fs_ready, fs_oe, fs_busy, fs_underrun);
    end
    checks++;
    if ({fs_plus, fs_minus} !== 2'b10 || {ls_plus, ls_minus} !== 2'b01) begin
      errors++;
      $display("FAIL reset_lines: fs=%b ls=%b, required fs=10 ls=01",
               {fs_plus, fs_minus}, {ls_plus, ls_minus});
    end
    reset = 1'b0;
    @(negedge hi_clock);
    checks++;
    if (fs_ready !== 1'b1 || ls_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: fs=%b ls=%b, required 1", fs_ready, ls_ready);
    end
  endtask

  // Sends up to three bytes, answering each tx_ready pulse, and checks every cycle of the packet.
  task automatic run_pkt(input string name, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input int nb, input bit last_final,
                         input string exp, input int exp_pulses, input int exp_unders);
    logic [7:0] bytes [3];
    int n_cyc, pulses, unders, sent;
    bit bad_fs, bad_ls, bad_ctl, bad_pos;
    bytes = '{b0, b1, b2};
    n_cyc = exp.len() * 4;
    pulses = 0; unders = 0;
    bad_fs = 1'b0; bad_ls = 1'b0; bad_ctl = 1'b0; bad_pos = 1'b0;
    @(negedge hi_clock);
    checks++;
    if (fs_ready !== 1'b1 || fs_oe !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: ready=%b oe=%b, required ready=1 oe=0", name, fs_ready, fs_oe);
    end
    tx_data  = b0;
    tx_last  = (nb == 1) ? last_final : 1'b0;
    tx_valid = 1'b1;
    sent     = 1;
    for (int c = 0; c < n_cyc; c++) begin
      @(negedge hi_clock);
      if (!bad_fs && {fs_plus, fs_minus} !== exp_line(exp[c/4], 1'b0)) begin
        bad_fs = 1'b1;
        $display("FAIL %s_fs_line: cycle %0d got %b, required %b", name, c,
                 {fs_plus, fs_minus}, exp_line(exp[c/4], 1'b0));
      end
      if (!bad_ls && {ls_plus, ls_minus} !== exp_line(exp[c/4], 1'b1)) begin
        bad_ls = 1'b1;
        $display("FAIL %s_ls_line: cycle %0d got %b, required %b", name, c,
                 {ls_plus, ls_minus}, exp_line(exp[c/4], 1'b1));
      end
      if (!bad_ctl && (fs_oe !== 1'b1 || fs_busy !== 1'b1 || ls_oe !== 1'b1)) begin
        bad_ctl = 1'b1;
        $display("FAIL %s_oe_busy: cycle %0d oe=%b busy=%b ls_oe=%b, required 1",
                 name, c, fs_oe, fs_busy, ls_oe);
      end
      if (fs_underrun === 1'b1) unders++;
      tx_valid = 1'b0;
      if (fs_ready === 1'b1) begin
        pulses++;
        if (c % 4 != 3) bad_pos = 1'b1;
        if (sent < nb) begin
          tx_data  = bytes[sent];
          tx_last  = (sent == nb - 1) ? last_final : 1'b0;
          tx_valid = 1'b1;
          sent++;
        end
      end
    end
    tx_valid = 1'b0;
    checks += 3;
    if (bad_fs) errors++;
    if (bad_ls) errors++;
    if (bad_ctl) errors++;
    checks++;
    if (pulses != exp_pulses) begin
      errors++;
      $display("FAIL %s_ready_pulses: got %0d, required %0d", name, pulses, exp_pulses);
    end
    checks++;
    if (bad_pos) begin
      errors++;
      $display("FAIL %s_ready_slot: pulse outside last clock of a bit, required last clock", name);
    end
    checks++;
    if (unders != exp_unders) begin
      errors++;
      $display("FAIL %s_underrun: got %0d pulses, required %0d", name, unders, exp_unders);
    end
    @(negedge hi_clock);
    checks++;
    if (fs_oe !== 1'b0 || fs_busy !== 1'b0 || fs_ready !== 1'b1 || ls_oe !== 1'b0) begin
      errors++;
      $display("FAIL %s_end_idle: oe=%b busy=%b ready=%b ls_oe=%b, required 0 0 1 0",
               name, fs_oe, fs_busy, fs_ready, ls_oe);
    end
    checks++;
    if ({fs_plus, fs_minus} !== 2'b10 || {ls_plus, ls_minus} !== 2'b01) begin
      errors++;
      $display("FAIL %s_end_lines: fs=%b ls=%b, required fs=10 ls=01", name,
               {fs_plus, fs_minus}, {ls_plus, ls_minus});
    end
  endtask

  task automatic test_single_a5();
    run_pkt("a5", 8'hA5, 8'h00, 8'h00, 1, 1'b1, "KJKJKJKKKJJKJJKK00J", 0, 0);
  endtask

  task automatic test_single_ff();
    run_pkt("ff", 8'hFF, 8'h00, 8'h00, 1, 1'b1, "KJKJKJKKKKKKKJJJJ00J", 0, 0);
  endtask

  task automatic test_stuff_after_bit7();
    run_pkt("fc00", 8'hFC, 8'h00, 8'h00, 2, 1'b1, "KJKJKJKKJKKKKKKKJKJKJKJKJ00J", 1, 0);
  endtask

  task automatic test_back_to_back();
    run_pkt("b2b", 8'h3C, 8'h7E, 8'hC3, 3, 1'b1,
            "KJKJKJKKJKKKKKJKJJJJJJJKJJJKJKJJJ00J", 2, 0);
  endtask

  task automatic test_underrun();
    run_pkt("underrun", 8'h01, 8'h00, 8'h00, 1, 1'b0, "KJKJKJKKKJKJKJKJ00J", 1, 1);
  endtask

  task automatic test_reset_mid_packet();
    @(negedge hi_clock);
    tx_data = 8'h3C; tx_last = 1'b0; tx_valid = 1'b1;
    for (int c = 0; c < 70; c++) begin
      @(negedge hi_clock);
      tx_valid = 1'b0;
      if (fs_ready === 1'b1) begin
        tx_data = 8'h7E; tx_last = 1'b1; tx_valid = 1'b1;
      end
    end
    tx_valid = 1'b0;
    checks++;
    if (fs_oe !== 1'b1) begin
      errors++;
      $display("FAIL mid_active: oe=%b before reset, required 1", fs_oe);
    end
    reset = 1'b1;
    @(negedge hi_clock);
    checks++;
    if (fs_oe !== 1'b0 || ls_oe !== 1'b0 || fs_busy !== 1'b0 || fs_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_abort: oe=%b ls_oe=%b busy=%b ready=%b, required all 0",
               fs_oe, ls_oe, fs_busy, fs_ready);
    end
    checks++;
    if ({fs_plus, fs_minus} !== 2'b10 || {ls_plus, ls_minus} !== 2'b01) begin
      errors++;
      $display("FAIL mid_lines: fs=%b ls=%b, required fs=10 ls=01",
               {fs_plus, fs_minus}, {ls_plus, ls_minus});
    end
    reset = 1'b0;
    @(negedge hi_clock);
    checks++;
    if (fs_ready !== 1'b1 || fs_oe !== 1'b0) begin
      errors++;
      $display("FAIL mid_release: ready=%b oe=%b, required ready=1 oe=0", fs_ready, fs_oe);
    end
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_single_ff();
    test_stuff_after_bit7();
    test_back_to_back();
    test_underrun();
    test_reset_mid_packet();
    test_single_a5();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_tx_serializer.md
USB_TX_SERIALIZER -- requirements
Module: usb_tx_serializer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, giving hi_clock cycles per USB bit time (48 MHz / 12 Mb/s).
REQ-002 SHALL have parameter LOW_SPEED, default 0: 0 means J = D+ high and D- low; 1 means J = D+ low and D- high.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 hi_clock  in  1  sole clock, rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 tx_data  in  8  packet byte, sent LSB first.
REQ-007 tx_valid  in  1  tx_data/tx_last valid.
REQ-008 tx_last  in  1  marks final byte of packet.
REQ-009 tx_ready  out  1  byte accepted when tx_valid & tx_ready.
REQ-010 tx_plus  out  1  D+ line level (maps to host_tx_plus).
REQ-011 tx_minus  out  1  D- line level (maps to host_tx_minus).
REQ-012 tx_oe  out  1  line driver enable, high for the whole packet.
REQ-013 tx_busy  out  1  high outside IDLE.
REQ-014 tx_underrun  out  1  one-cycle pulse on data underrun.

Function
REQ-015 SHALL implement states IDLE, SYNC, DATA, EOP_SE0, EOP_J.
REQ-016 IDLE: tx_ready=1, tx_oe=0, lines at J; a handshake loads the byte and moves to SYNC; tx_oe=1 and the first K SHALL appear on the following cycle.
REQ-017 Each line symbol SHALL persist exactly CLKS_PER_BIT cycles, timed by a bit counter that restarts on leaving IDLE.
REQ-018 SYNC SHALL send raw bits 0000_0001 (LSB first) through NRZI, giving KJKJKJKK, then enter DATA.
REQ-019 NRZI: a 0 bit toggles J/K, a 1 bit holds the level; the NRZI state starts at J on every packet.
REQ-020 Bit stuffing: after six consecutive raw 1s, a 0 SHALL be inserted; the ones counter SHALL include the final SYNC 1 (counter=1 on entering DATA) and reset on any 0, including stuffed 0s.
REQ-021 A stuffed bit SHALL also follow the last data bit when required, before EOP.
REQ-022 In the last clock of bit 7 of a non-last byte, tx_ready SHALL be 1 for exactly that cycle; if tx_valid=1 the byte is loaded, otherwise tx_underrun pulses and the state goes to EOP_SE0 after the current bit (and any stuff bit).
REQ-023 tx_ready SHALL be 0 in every other non-IDLE cycle; tx_data is ignored then.
REQ-024 After bit 7 (plus any stuff bit) of a tx_last byte, the state SHALL go to EOP_SE0.
REQ-025 EOP_SE0 SHALL drive tx_plus=tx_minus=0 for 2 bit times, then EOP_J drives J for 1 bit time, then IDLE with tx_oe=0.
REQ-026 Total bit times SHALL be 8 + 8N + stuff bits + 3.
REQ-027 tx_busy SHALL equal (state != IDLE), registered.

Reset
REQ-028 Under reset: state IDLE, tx_oe=0, lines at J, tx_ready=0, tx_busy=0, tx_underrun=0, counters 0.
REQ-029 reset mid-packet SHALL abort immediately, with no EOP; tx_oe=0 the cycle after reset is sampled.
REQ-030 tx_ready SHALL rise on the first cycle after reset deasserts.

Structure
REQ-031 Shared package usb_hub_pkg SHALL hold the state encoding, SYNC_PATTERN=8'h80, STUFF_LIMIT=6, and J/K/SE0 line-level constants.
REQ-032 NRZI encoding and the stuff counter SHALL live in sub-module usb_nrzi_stuffer (bit in, stuff request, line out).

Verification
REQ-033 Send single byte 0xA5 with tx_last -> KJKJKJKK, NRZI of 1,0,1,0,0,1,0,1, SE0 for 8 clocks, J for 4 clocks, tx_oe low; 19 bit times total.
REQ-034 Send single byte 0xFF with tx_last -> stuffed 0 (transition) after data bit 4; 20 bit times total.
REQ-035 Send bytes 0x3C, 0x7E, 0xC3 back to back -> tx_ready pulses exactly twice, no gaps between bytes, EOP after 0xC3.
REQ-036 Send 0x01 (not last) with tx_valid dropped at the fetch cycle -> tx_underrun pulse, EOP follows, return to IDLE.
REQ-037 Assert reset during the 2nd data byte -> tx_oe=0 the next cycle, lines at J, tx_ready=1 one cycle after release.
REQ-038 Repeat REQ-033 with LOW_SPEED=1 -> D+/D- polarity inverted, SE0 unchanged.
